mips_mc_controller: RTL

- Multicycle control FSM that sequences the existing datapath/ram/rom resources one instruction over 3-5 states, instead of the single-cycle combinational control unit.
- Drives the mux selects, write enables and ALU control for a shared-memory multicycle datapath.
- Supports: R-type (add, sub, and, or, slt, nor), lw, sw, beq, addi, j.
- Optional memory wait states let a slower RAM be shared without datapath changes.

---
 rtl/mips_mc_pkg.sv | 52 +++++
 rtl/mips_mc_alu_decoder.sv | 37 +++
 rtl/mips_mc_controller.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// function codes and ALU control values.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // ALUOp 11 is unused by the single-cycle control; here it parks the ALU on AND.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IDLE  = 2'b11;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_mc_alu_decoder.sv
// ALU decoder: (ALUOp, Funct) -> ALUControl, plus a flag saying Funct is supported.
// Purely combinational; shared between single-cycle and multicycle control.
module mc_alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       funct_legal
);

    logic [3:0] funct_ctl;

    always_comb begin
        funct_legal = 1'b1;
        funct_ctl   = ALU_ADD;
        case (funct)
            FN_ADD:  funct_ctl = ALU_ADD;
            FN_SUB:  funct_ctl = ALU_SUB;
            FN_AND:  funct_ctl = ALU_AND;
            FN_OR:   funct_ctl = ALU_OR;
            FN_SLT:  funct_ctl = ALU_SLT;
            FN_NOR:  funct_ctl = ALU_NOR;
            default: funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_ctl;
            default:     alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: Moore outputs decoded from the state register,
// with optional memory wait states in FETCH, MEMREAD and MEMWRITE.
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [3:0] ALUControl,
    output logic [3:0] State,
    output logic       Illegal
);

    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic       wait_done;
    logic       wait_state;
    logic [1:0] alu_op;
    logic [3:0] dec_ctl;
    logic       funct_legal;
    logic       decode_illegal;
    logic       pc_write;
    logic       branch;

    mc_alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct       (Funct),
        .alu_control (dec_ctl),
        .funct_legal (funct_legal)
    );

    assign wait_done      = (wait_cnt == WAIT_MAX);
    assign wait_state     = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign decode_illegal = !op_legal(Op) || ((Op == OP_R) && !funct_legal);
    assign State          = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    if (wait_done) state_nxt = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = funct_legal ? S_EXECUTE : S_FETCH;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_ADDIEXEC;
                    OP_J:         state_nxt = S_JUMP;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nxt = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (wait_done) state_nxt = S_MEMWB;
            S_MEMWRITE: if (wait_done) state_nxt = S_FETCH;
            S_EXECUTE:  state_nxt = S_ALUWB;
            S_ADDIEXEC: state_nxt = S_ADDIWB;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // The counter saturates at MEM_WAIT and restarts on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                wait_cnt <= 4'd0;
            else if (wait_state && !wait_done)
                wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_comb begin
        case (state)
            S_FETCH, S_DECODE, S_MEMADR, S_ADDIEXEC: alu_op = ALUOP_ADD;
            S_BRANCH:                                alu_op = ALUOP_SUB;
            S_EXECUTE:                               alu_op = ALUOP_FUNCT;
            default:                                 alu_op = ALUOP_IDLE;
        endcase
    end

    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUControl = dec_ctl;
        Illegal    = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB  = 2'b01;
                IRWrite  = wait_done;
                pc_write = wait_done;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                Illegal = decode_illegal;
            end
            S_MEMADR, S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD:  IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE:  ALUSrcA = 1'b1;
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIWB:   RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        PCEn = pc_write | (branch & Zero);
        // Reset overrides combinationally so a write in flight dies the instant reset rises.
        if (reset) begin
            PCEn       = 1'b0;
            IorD       = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            PCSrc      = 2'b00;
            ALUControl = ALU_ADD;
            Illegal    = 1'b0;
        end
    end

endmodule
